// File: rtl/irrigation_pkg.sv
// Shared constants, width helpers and FSM state type for the irrigation defuzzifier.
package irrigation_pkg;

    localparam int C_POUCO_D = 40;
    localparam int C_MEDIO_D = 128;
    localparam int C_MUITO_D = 230;

    // Numerator holds three W x W products; denominator holds three W-bit sums.
    function automatic int num_width(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int den_width(input int w);
        return w + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/defuzzifier_seq_divider.sv
// Unsigned restoring divider (module seq_divider_u): one quotient bit per cycle, MSB first,
// NUM_W cycles after start; done flags the cycle whose closing edge completes the result.
module seq_divider_u #(
    parameter int NUM_W = 18,
    parameter int DEN_W = 10,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(NUM_W);

    logic [NUM_W-1:0] dq;
    logic [NUM_W-1:0] dq_next;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] rem_next;
    logic [DEN_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   diff;

    // dq starts as the dividend; each step shifts one dividend bit out and one quotient bit in.
    always_comb begin
        shifted  = {rem, dq[NUM_W-1]};
        diff     = shifted - {1'b0, dvs};
        rem_next = shifted[DEN_W-1:0];
        dq_next  = {dq[NUM_W-2:0], 1'b0};
        if (shifted >= {1'b0, dvs}) begin
            rem_next = diff[DEN_W-1:0];
            dq_next  = {dq[NUM_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq      <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            dq      <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            cnt     <= CNT_W'(NUM_W - 1);
            running <= 1'b1;
        end else if (running) begin
            dq  <= dq_next;
            rem <= rem_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                running <= 1'b0;
            end
        end
    end

    assign done     = running && (cnt == '0);
    assign quotient = dq_next[Q_W-1:0];

endmodule

// File: rtl/defuzzifier_seq.sv
// Sequential centroid defuzzifier: crisp = sum(strength*centroid) / sum(strength).
// Optional PWM pump drive enabled by defining DEFUZZ_PWM_EN.
module defuzzifier_seq
    import irrigation_pkg::*;
#(
    parameter int W       = 8,
    parameter int C_POUCO = C_POUCO_D,
    parameter int C_MEDIO = C_MEDIO_D,
    parameter int C_MUITO = C_MUITO_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] irrigar_pouco,
    input  logic [W-1:0] irrigar_medio,
    input  logic [W-1:0] irrigar_muito,
    output logic         out_valid,
    output logic [W-1:0] crisp_out,
    output logic         busy,
    output logic         pump_pwm
);

    localparam int NUM_W = num_width(W);
    localparam int DEN_W = den_width(W);

    state_t       state;
    state_t       state_next;
    logic [W-1:0] p_lat;
    logic [W-1:0] m_lat;
    logic [W-1:0] h_lat;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic             den_zero;
    logic             div_start;
    logic             div_done;
    logic [W-1:0]     div_q;

    always_comb begin
        num = NUM_W'(p_lat) * NUM_W'(C_POUCO)
            + NUM_W'(m_lat) * NUM_W'(C_MEDIO)
            + NUM_W'(h_lat) * NUM_W'(C_MUITO);
        den = DEN_W'(p_lat) + DEN_W'(m_lat) + DEN_W'(h_lat);
    end

    assign den_zero  = (den == '0);
    assign div_start = (state == SUM) && !den_zero;

    // The divider captures num/den at the edge leaving SUM.
    seq_divider_u #(
        .NUM_W(NUM_W),
        .DEN_W(DEN_W),
        .Q_W  (W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(num),
        .divisor (den),
        .done    (div_done),
        .quotient(div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = SUM;
                end
            end
            SUM: begin
                state_next = den_zero ? DONE : DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_lat <= '0;
            m_lat <= '0;
            h_lat <= '0;
        end else if (state == IDLE && in_valid) begin
            p_lat <= irrigar_pouco;
            m_lat <= irrigar_medio;
            h_lat <= irrigar_muito;
        end
    end

    // Result lands on the edge entering DONE so it is valid alongside out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crisp_out <= '0;
        end else if (state == SUM && den_zero) begin
            crisp_out <= '0;
        end else if (state == DIV && div_done) begin
            crisp_out <= div_q;
        end
    end

`ifdef DEFUZZ_PWM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] duty;

    // Duty reloads only at the period boundary so a new result never truncates a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) begin
                duty <= crisp_out[W-1:W-8];
            end
        end
    end

    assign pump_pwm = (pwm_cnt < duty);
`else
    assign pump_pwm = 1'b0;
`endif

endmodule

// File: tb/tb_defuzzifier_seq.sv
// Directed bench for defuzzifier_seq with a queue scoreboard of expected crisp results.
module tb_defuzzifier_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] irrigar_pouco = '0;
    logic [7:0] irrigar_medio = '0;
    logic [7:0] irrigar_muito = '0;
    logic       out_valid;
    logic [7:0] crisp_out;
    logic       busy;
    logic       pump_pwm;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    bit         pwm_seen = 1'b0;

    defuzzifier_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .irrigar_pouco(irrigar_pouco),
        .irrigar_medio(irrigar_medio),
        .irrigar_muito(irrigar_muito),
        .out_valid    (out_valid),
        .crisp_out    (crisp_out),
        .busy         (busy),
        .pump_pwm     (pump_pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] model(input int p, input int m, input int h);
        int den;
        den = p + m + h;
        if (den == 0) return 8'd0;
        return 8'((p * 40 + m * 128 + h * 230) / den);
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("crisp", {24'd0, crisp_out}, {24'd0, e});
            end
        end
        if (pump_pwm) pwm_seen = 1'b1;
    end

    // Drive a sample and return just after its accepting edge with in_valid still high.
    task automatic start(input logic [7:0] p, input logic [7:0] m, input logic [7:0] h, input bit score);
        int n;
        irrigar_pouco = p;
        irrigar_medio = m;
        irrigar_muito = h;
        in_valid      = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk);
        if (score) exp_q.push_back(model(p, m, h));
        #1;
    endtask

    // Called in cycle 1 after the handshake; returns in the out_valid cycle.
    task automatic wait_result(input int lat, input string tag);
        int k;
        k = 1;
        check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        check({tag, "_ready1"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && k < 60) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic send(input logic [7:0] p, input logic [7:0] m, input logic [7:0] h,
                        input int lat, input string tag);
        start(p, m, h, 1'b1);
        in_valid = 1'b0;
        wait_result(lat, tag);
    endtask

    initial begin
        int hi;
        repeat (3) @(posedge clk);
        #1;
        check("rst_crisp", {24'd0, crisp_out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_crisp", {24'd0, crisp_out}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        send(8'd0, 8'd0, 8'd255, 20, "muito");

        // Second sample is presented while busy and must wait for IDLE.
        start(8'd255, 8'd255, 8'd0, 1'b1);
        irrigar_pouco = 8'd100;
        irrigar_medio = 8'd100;
        irrigar_muito = 8'd200;
        wait_result(20, "b2b_a");
        @(posedge clk); #1;
        check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        exp_q.push_back(model(100, 100, 200));
        #1;
        in_valid = 1'b0;
        wait_result(20, "b2b_b");

        send(8'd0, 8'd0, 8'd0, 2, "zero");
        send(8'd255, 8'd255, 8'd255, 20, "all_max");
        send(8'd1, 8'd0, 8'd0, 20, "single_p");
        send(8'd3, 8'd2, 8'd1, 20, "mixed");

        // Abort in cycle 10: the pending result must never appear.
        start(8'd0, 8'd0, 8'd255, 1'b0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_crisp", {24'd0, crisp_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        send(8'd0, 8'd255, 8'd0, 20, "after_abort");

`ifdef DEFUZZ_PWM_EN
        send(8'd0, 8'd0, 8'd255, 20, "pwm_src");
        repeat (300) @(posedge clk);
        #1;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (pump_pwm) hi++;
            @(posedge clk); #1;
        end
        check("pwm_high_count", hi, 230);
`else
        hi = 0;
        repeat (50) @(posedge clk);
        check("pwm_tied_low", {31'd0, pwm_seen}, 32'd0);
`endif
        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/defuzzifier_seq.md
Name: defuzzifier_seq

Overview:
- Sequential centroid defuzzifier, directly downstream of the fuzzy rule engine.
- Takes the three aggregated output strengths (irrigar_pouco / medio / muito) and computes the crisp pump command: crisp = (p*C_POUCO + m*C_MEDIO + h*C_MUITO) / (p+m+h).
- Uses a multi-cycle restoring divider with a valid/ready input handshake.
- Optionally drives the pump directly via PWM.

Parameters:
- W, 8, width of strengths, centroids and crisp output.
- C_POUCO, 40, centroid of "irrigar pouco" set (must be ≤ 2^W-1).
- C_MEDIO, 128, centroid of "irrigar medio" set.
- C_MUITO, 230, centroid of "irrigar muito" set.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  rule-engine strengths valid.
- in_ready  out  1  block can accept a new sample.
- irrigar_pouco  in  W  strength p.
- irrigar_medio  in  W  strength m.
- irrigar_muito  in  W  strength h.
- out_valid  out  1  one-cycle pulse: crisp_out updated.
- crisp_out  out  W  crisp irrigation intensity, held until next result.
- busy  out  1  high in any state other than IDLE.
- pump_pwm  out  1  PWM pump drive (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, crisp_out=0, out_valid=0, busy=0, in_ready=1, pump_pwm=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the calculation; no out_valid is produced.
- Widths:
  - NUM_W = 2W+2 (18 bits at W=8; max 3*255*255 = 195075).
  - DEN_W = W+2 (max 765).
  - Quotient fits in W bits because the weighted mean ≤ max centroid.
  - Truncating division, no rounding.
- FSM states IDLE, SUM, DIV, DONE:
  - IDLE: in_ready=1. On in_valid && in_ready at the edge, latch p, m, h → SUM. Inputs are ignored otherwise.
  - SUM (1 cycle): register num = p*C_POUCO + m*C_MEDIO + h*C_MUITO and den = p+m+h.
    - If den==0 → DONE with quotient forced to 0 (no rule fired = no irrigation).
    - Else → DIV, bit counter = NUM_W-1.
  - DIV: one restoring-division step per cycle, MSB first, for NUM_W cycles (18). After the last step → DONE.
  - DONE (1 cycle): crisp_out ← quotient[W-1:0], out_valid=1 → IDLE.
- in_ready=0 in SUM, DIV and DONE. No input buffering; the upstream must hold in_valid.
- Latency, with the handshake edge = cycle 0:
  - Normal: out_valid high during cycle NUM_W+2 (cycle 20 at W=8).
  - den==0: out_valid high during cycle 2.
- Throughput: the earliest next accept is the edge ending the cycle after DONE (IDLE lasts ≥1 cycle).
- crisp_out changes only in DONE.

Optional Feature:
- Macro: DEFUZZ_PWM_EN.
- When defined:
  - 8-bit free-running counter cnt, wrapping 255→0.
  - duty register loaded from crisp_out[W-1:W-8] only when cnt==255, so the period is glitch-free.
  - pump_pwm = (cnt < duty). Duty 0 means always low; duty 255 means high 255 of 256 cycles.
  - Reset clears cnt and duty.
- When undefined: no counter or duty logic; pump_pwm tied 0. The port list is unchanged in both builds.

Decomposition:
- Package irrigation_pkg holds:
  - Default centroid constants (C_POUCO_D=40, C_MEDIO_D=128, C_MUITO_D=230).
  - Width helpers NUM_W and DEN_W.
  - FSM state enum (IDLE, SUM, DIV, DONE).
- One natural sub-module: seq_divider_u, an unsigned restoring divider (start/done, NUM_W/DEN_W parameters, NUM_W-cycle latency). The FSM sequences it.

Test Plan:
- Reset then idle: after rst_n release, crisp_out=0, out_valid=0, in_ready=1, busy=0.
- p=0, m=0, h=255 → crisp_out=230, out_valid pulse at cycle 20, busy high cycles 1–20.
- p=255, m=255, h=0 → crisp_out=84 (42840/510). Then p=100, m=100, h=200 → crisp_out=157 (62800/400). Back-to-back: in_valid held high during busy is not accepted until IDLE.
- p=m=h=0 → crisp_out=0, out_valid at cycle 2, no DIV cycles.
- Reset mid-operation: assert rst_n=0 at cycle 10 of a calculation → immediate async clear, no out_valid. The next sample (0,255,0) → 128.
- DEFUZZ_PWM_EN build: crisp=230 → pump_pwm high exactly 230 of 256 cycles per period; a crisp change mid-period takes effect only after cnt wraps. Non-PWM build: pump_pwm stays 0.
